bitreversal_seq: RTL and testbench

- Sequencer between the bit-reversal control-register block and the bit-reversal core.
- Converts software-held start/write/read levels into single-cycle core commands.
- Enforces the block protocol: load N words, run, wait for done, unload N words.
- Provides done/result/error status back to the register file; a run timeout is included.

---
 rtl/bitreversal_seq_if.sv | 16 +
 rtl/bitreversal_seq.sv | 170 +++++++++++++++++
 tb/tb_bitreversal_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitreversal_seq_if.sv
// bitreversal_seq_if: command/data handshake between the sequencer (master) and the bit-reversal core (slave).
interface bitreversal_seq_if #(
    parameter int DW = 32
);
    logic          wr;
    logic [DW-1:0] wdata;
    logic          start;
    logic          abort;
    logic          done;
    logic          rd;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (output wr, wdata, start, abort, rd, input done, rdata, rvalid);
    modport slave  (input wr, wdata, start, abort, rd, output done, rdata, rvalid);
endinterface

// File: rtl/bitreversal_seq.sv
// bitreversal_seq: turns software start/write/read levels into single-cycle core commands and
// enforces the load-run-unload block protocol with sticky error status and a run timeout.
module bitreversal_seq #(
    parameter int N_WORDS = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    localparam int CW     = $clog2(N_WORDS + 1),
    localparam int TW     = $clog2(TIMEOUT)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic           write_i,
    input  logic           read_i,
    input  logic [DW-1:0]  din_i,
    input  logic           err_clr_i,
    output logic           done_o,
    output logic [DW-1:0]  dout_o,
    output logic           busy_o,
    output logic [2:0]     err_o,
    output logic [CW-1:0]  wcnt_o,
    output logic [CW-1:0]  rcnt_o,
    bitreversal_seq_if.master core
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    prev_q, prev_d;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pend_q, pend_d, done_q, done_d;
    logic [DW-1:0] dout_q, dout_d, wdata_q, wdata_d;
    logic [2:0]    err_q, err_d, err_new;
    logic          wr_q, wr_d, start_q, start_d, abort_q, abort_d, rd_q, rd_d;
    logic          rs, rw, rr, sel_s, sel_w, sel_r, full;

    assign rs    = start_i & ~prev_q[2];
    assign rw    = write_i & ~prev_q[1];
    assign rr    = read_i  & ~prev_q[0];
    assign sel_s = rs;
    assign sel_w = rw & ~rs;
    assign sel_r = rr & ~rs & ~rw;
    assign full  = wcnt_q == CW'(N_WORDS);

    always_comb begin
        state_d = state_q;
        prev_d  = {start_i, write_i, read_i};
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        pend_d  = pend_q;
        done_d  = done_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        start_d = 1'b0;
        abort_d = 1'b0;
        rd_d    = 1'b0;
        err_new = 3'b000;
        // every rise that loses the priority pick is a protocol error
        err_new[0] = (rs & rw) | (rs & rr) | (rw & rr);
        case (state_q)
            IDLE: begin
                if (sel_w) begin
                    wr_d    = 1'b1;
                    wdata_d = din_i;
                    wcnt_d  = CW'(1);
                    rcnt_d  = '0;
                    done_d  = 1'b0;
                    state_d = LOAD;
                end else if (sel_s | sel_r) err_new[0] = 1'b1;
            end
            LOAD: begin
                if (sel_s) begin
                    if (full) begin
                        start_d = 1'b1;
                        tcnt_d  = '0;
                        state_d = RUN;
                    end else err_new[0] = 1'b1;
                end else if (sel_w) begin
                    if (full) err_new[1] = 1'b1;
                    else begin
                        wr_d    = 1'b1;
                        wdata_d = din_i;
                        wcnt_d  = wcnt_q + CW'(1);
                    end
                end else if (sel_r) err_new[0] = 1'b1;
            end
            RUN: begin
                if (rs | rw | rr) err_new[0] = 1'b1;
                if (core.done) begin
                    done_d  = 1'b1;
                    state_d = UNLOAD;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    abort_d    = 1'b1;
                    err_new[2] = 1'b1;
                    wcnt_d     = '0;
                    state_d    = IDLE;
                end else tcnt_d = tcnt_q + TW'(1);
            end
            UNLOAD: begin
                if (sel_s | sel_w) err_new[0] = 1'b1;
                else if (sel_r) begin
                    if (pend_q) err_new[0] = 1'b1;
                    else begin
                        rd_d   = 1'b1;
                        pend_d = 1'b1;
                    end
                end
                if (core.rvalid && pend_q) begin
                    dout_d = core.rdata;
                    rcnt_d = rcnt_q + CW'(1);
                    pend_d = 1'b0;
                    if (rcnt_q == CW'(N_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_clr_i ? 3'b000 : err_q) | err_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prev_q  <= 3'b111;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            wdata_q <= '0;
            err_q   <= 3'b000;
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            start_q <= start_d;
            abort_q <= abort_d;
            rd_q    <= rd_d;
        end
    end

    assign done_o     = done_q;
    assign dout_o     = dout_q;
    assign busy_o     = (state_q == RUN) | pend_q;
    assign err_o      = err_q;
    assign wcnt_o     = wcnt_q;
    assign rcnt_o     = rcnt_q;
    assign core.wr    = wr_q;
    assign core.wdata = wdata_q;
    assign core.start = start_q;
    assign core.abort = abort_q;
    assign core.rd    = rd_q;
endmodule

// File: tb/tb_bitreversal_seq.sv
// tb_bitreversal_seq: directed checks of the bit-reversal sequencer with N_WORDS=8, TIMEOUT=16.
module tb_bitreversal_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, write = 1'b0, read = 1'b0, err_clr = 1'b0;
    logic [31:0] din = '0;
    logic        done, busy;
    logic [31:0] dout;
    logic [2:0]  err;
    logic [3:0]  wcnt, rcnt;
    int          checks = 0, errors = 0;
    int          wr_n = 0, start_n = 0, abort_n = 0, rd_n = 0;
    logic [31:0] wlog [0:63];

    bitreversal_seq_if #(.DW(32)) cif ();

    bitreversal_seq #(.N_WORDS(8), .DW(32), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .write_i(write), .read_i(read),
        .din_i(din), .err_clr_i(err_clr), .done_o(done), .dout_o(dout), .busy_o(busy),
        .err_o(err), .wcnt_o(wcnt), .rcnt_o(rcnt), .core(cif.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cif.wr) begin
            if (wr_n < 64) wlog[wr_n] = cif.wdata;
            wr_n++;
        end
        if (cif.start) start_n++;
        if (cif.abort) abort_n++;
        if (cif.rd) rd_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] d);
        din = d;
        write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    task automatic do_read(input int i);
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        tick();
        tick();
        cif.rdata = 32'hA0 + i;
        cif.rvalid = 1'b1;
        tick();
        cif.rvalid = 1'b0;
        cif.rdata = '0;
        tick();
    endtask

    task automatic load8();
        for (int i = 1; i <= 8; i++) do_write(i);
    endtask

    task automatic run_done();
        int bc;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) bc++;
            if (i == 4) cif.done = 1'b1;
            tick();
        end
        cif.done = 1'b0;
        chk("run_busy_cycles", bc, 5);
    endtask

    initial begin
        int s0, w0, r0, a0, bc;
        cif.done = 1'b0;
        cif.rdata = '0;
        cif.rvalid = 1'b0;
        #2;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wcnt", wcnt, 0);
        chk("rst_strobes", {cif.wr, cif.start, cif.abort, cif.rd}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        load8();
        chk("load_wr_count", wr_n, 8);
        for (int i = 0; i < 8; i++) chk("load_wdata", wlog[i], i + 1);
        chk("load_wcnt", wcnt, 8);
        chk("load_err", err, 0);

        run_done();
        chk("run_start_pulses", start_n, 1);
        chk("run_done_o", done, 1);
        chk("unload_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            do_read(i);
            chk("unload_dout", dout, 32'hA0 + i);
            chk("unload_rcnt", rcnt, i + 1);
        end
        chk("unload_rd_count", rd_n, 8);
        chk("idle_wcnt", wcnt, 0);
        chk("idle_done_held", done, 1);
        chk("idle_err", err, 0);
        tick();
        chk("idle_rcnt_held", rcnt, 8);

        do_write(32'h11);
        chk("newblk_done_clr", done, 0);
        chk("newblk_wcnt", wcnt, 1);
        chk("newblk_rcnt", rcnt, 0);
        for (int i = 0; i < 4; i++) do_write(32'h20 + i);
        s0 = start_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("early_start_err", err, 3'b001);
        chk("early_start_nopulse", start_n, s0);
        chk("early_start_wcnt", wcnt, 5);
        for (int i = 0; i < 3; i++) do_write(32'h30 + i);
        w0 = wr_n;
        do_write(32'h99);
        chk("overflow_err", err, 3'b011);
        chk("overflow_nowr", wr_n, w0);
        chk("overflow_wcnt", wcnt, 8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err, 0);

        a0 = abort_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bc++;
            tick();
        end
        chk("timeout_busy_cycles", bc, 16);
        chk("timeout_abort", abort_n, a0 + 1);
        chk("timeout_err", err, 3'b100);
        chk("timeout_wcnt", wcnt, 0);
        chk("timeout_done", done, 0);

        write = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_clears_err", err, 0);
        tick();
        rst_n = 1'b1;
        w0 = wr_n;
        tick();
        tick();
        tick();
        chk("held_write_no_wr", wr_n, w0);
        chk("held_write_wcnt", wcnt, 0);
        write = 1'b0;
        tick();

        load8();
        run_done();
        r0 = rd_n;
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        chk("pend_busy", busy, 1);
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        chk("pend_second_err", err, 3'b001);
        chk("pend_one_rd", rd_n, r0 + 1);
        cif.rdata = 32'h55;
        cif.rvalid = 1'b1;
        tick();
        cif.rvalid = 1'b0;
        chk("pend_dout", dout, 32'h55);
        chk("pend_rcnt", rcnt, 1);
        cif.rvalid = 1'b1;
        tick();
        cif.rvalid = 1'b0;
        chk("stray_rvalid_rcnt", rcnt, 1);
        chk("stray_rvalid_err", err, 3'b001);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        load8();
        a0 = abort_n;
        start = 1'b1;
        read = 1'b1;
        tick();
        start = 1'b0;
        read = 1'b0;
        chk("simul_rise_err", err, 3'b001);
        chk("simul_busy", busy, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("runrst_busy", busy, 0);
        chk("runrst_done", done, 0);
        chk("runrst_err", err, 0);
        chk("runrst_cnts", {wcnt, rcnt}, 0);
        chk("runrst_dout", dout, 0);
        chk("runrst_strobes", {cif.wr, cif.start, cif.abort, cif.rd}, 0);
        tick();
        tick();
        chk("runrst_no_abort", abort_n, a0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
